// File: rtl/sprite_pkg.sv
// Shared constants and per-mode slot table for the sprite scheduler.
// Rectangles are half-open [x0,x1) x [y0,y1) in active-pixel coordinates.
package sprite_pkg;

  localparam int MAX_SLOTS = 4;

  localparam logic [23:0] BG_DEFAULT = 24'h150088;
  localparam logic [23:0] BG_MODE2   = 24'h946d29;

  typedef enum logic [2:0] {
    ID_NONE   = 3'd0,
    ID_LOGO   = 3'd1,
    ID_START  = 3'd2,
    ID_PLAYER = 3'd3,
    ID_ROW1   = 3'd4,
    ID_ROW2   = 3'd5,
    ID_ROW3   = 3'd6,
    ID_DICE   = 3'd7
  } sprite_id_e;

  typedef struct packed {
    logic       valid;
    sprite_id_e id;
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
  } slot_t;

  function automatic slot_t mk(
    input sprite_id_e  id,
    input int unsigned x0,
    input int unsigned x1,
    input int unsigned y0,
    input int unsigned y1
  );
    slot_t s;
    s.valid = 1'b1;
    s.id    = id;
    s.x0    = 10'(x0);
    s.x1    = 10'(x1);
    s.y0    = 10'(y0);
    s.y1    = 10'(y1);
    return s;
  endfunction

  function automatic slot_t slot_lookup(
    input logic [31:0] mode,
    input logic [1:0]  idx
  );
    slot_t s;
    s = '0;
    unique case (mode)
      32'd0: begin
        unique case (idx)
          2'd0:    s = mk(ID_LOGO, 63, 559, 81, 186);
          2'd1:    s = mk(ID_START, 228, 400, 204, 372);
          default: s = '0;
        endcase
      end
      32'd1: begin
        unique case (idx)
          2'd0:    s = mk(ID_LOGO, 63, 559, 81, 186);
          2'd1:    s = mk(ID_PLAYER, 230, 399, 205, 461);
          default: s = '0;
        endcase
      end
      32'd3: begin
        unique case (idx)
          2'd0: s = mk(ID_ROW1, 18, 617, 18, 97);
          2'd1: s = mk(ID_ROW2, 31, 615, 124, 227);
          2'd2: s = mk(ID_ROW3, 195, 437, 239, 302);
          2'd3: s = mk(ID_DICE, 4, 635, 344, 463);
        endcase
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite window: rectangle hit test plus its running pixel counter.
// The counter advances on every evaluated hit so covered sprites stay unsheared.
module sprite_slot
  import sprite_pkg::*;
#(
  parameter logic [1:0] IDX = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        eval,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [31:0] mode,
  output logic        hit,
  output sprite_id_e  id,
  output logic [18:0] cnt
);

  slot_t       slot;
  logic [18:0] cnt_d;
  logic [18:0] cnt_q;

  always_comb begin
    slot  = slot_lookup(mode, IDX);
    id    = slot.id;
    hit   = slot.valid
          && (x >= slot.x0) && (x < slot.x1)
          && (y >= slot.y0) && (y < slot.y1);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (eval && hit) begin
      cnt_d = cnt_q + 19'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sprite_scheduler.sv
// Per-pixel sprite scheduler: position tracking, per-frame mode latch,
// slot priority and registered ROM address / sprite ID outputs.
module sprite_scheduler
  import sprite_pkg::*;
(
  input  logic        iVGA_CLK,
  input  logic        reset,
  input  logic        blank_n,
  input  logic        vs,
  input  logic [31:0] mode_in,
  output logic        pix_valid,
  output logic [2:0]  sprite_id,
  output logic [18:0] rom_addr,
  output logic [23:0] bg_bgr,
  output logic        frame_start
);

  logic        eval;
  logic        clr;
  logic [9:0]  x_d, x_q;
  logic [9:0]  y_d, y_q;
  logic [31:0] mode_d, mode_q;
  logic        vs_prev_d, vs_prev_q;
  logic        valid_d, valid_q;
  sprite_id_e  id_d, id_q;
  logic [18:0] addr_d, addr_q;
  logic        fs_d, fs_q;

  logic [MAX_SLOTS-1:0] hit;
  sprite_id_e           ids  [MAX_SLOTS];
  logic [18:0]          cnts [MAX_SLOTS];
  sprite_id_e           win_id;
  logic [18:0]          win_addr;

  // Sync wins over blanking, so a malformed vs/blank_n overlap evaluates nothing.
  assign clr  = ~vs;
  assign eval = vs & blank_n;

  for (genvar g = 0; g < MAX_SLOTS; g++) begin : g_slot
    sprite_slot #(
      .IDX(2'(g))
    ) u_slot (
      .clk (iVGA_CLK),
      .rst (reset),
      .clr (clr),
      .eval(eval),
      .x   (x_q),
      .y   (y_q),
      .mode(mode_q),
      .hit (hit[g]),
      .id  (ids[g]),
      .cnt (cnts[g])
    );
  end

  always_comb begin
    win_id   = ID_NONE;
    win_addr = '0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_id   = ids[i];
        win_addr = cnts[i];
      end
    end

    x_d = x_q;
    y_d = y_q;
    if (!vs) begin
      x_d = '0;
      y_d = '0;
    end else if (blank_n) begin
      x_d = x_q + 10'd1;
    end else if (x_q != '0) begin
      x_d = '0;
      y_d = y_q + 10'd1;
    end

    mode_d    = vs ? mode_q : mode_in;
    vs_prev_d = vs;
    fs_d      = vs_prev_q & ~vs;
    valid_d   = eval;
    id_d      = eval ? win_id : ID_NONE;
    addr_d    = eval ? win_addr : '0;
  end

  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      mode_q    <= '0;
      vs_prev_q <= 1'b1;
      valid_q   <= 1'b0;
      id_q      <= ID_NONE;
      addr_q    <= '0;
      fs_q      <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      mode_q    <= mode_d;
      vs_prev_q <= vs_prev_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      fs_q      <= fs_d;
    end
  end

  assign pix_valid   = valid_q;
  assign sprite_id   = id_q;
  assign rom_addr    = addr_q;
  assign frame_start = fs_q;
  assign bg_bgr      = (mode_q == 32'd2) ? BG_MODE2 : BG_DEFAULT;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Randomized line-length bench for sprite_scheduler against a per-line
// arithmetic model of sprite addresses.
module tb_sprite_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        blank_n = 1'b0;
  logic        vs = 1'b1;
  logic [31:0] mode_in = '0;
  logic        pix_valid;
  logic [2:0]  sprite_id;
  logic [18:0] rom_addr;
  logic [23:0] bg_bgr;
  logic        frame_start;

  sprite_scheduler dut (
    .iVGA_CLK   (clk),
    .reset      (reset),
    .blank_n    (blank_n),
    .vs         (vs),
    .mode_in    (mode_in),
    .pix_valid  (pix_valid),
    .sprite_id  (sprite_id),
    .rom_addr   (rom_addr),
    .bg_bgr     (bg_bgr),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int tid [4][4] = '{'{1, 2, 0, 0}, '{1, 3, 0, 0},
                     '{0, 0, 0, 0}, '{4, 5, 6, 7}};
  int tx0 [4][4] = '{'{63, 228, 0, 0}, '{63, 230, 0, 0},
                     '{0, 0, 0, 0}, '{18, 31, 195, 4}};
  int tx1 [4][4] = '{'{559, 400, 0, 0}, '{559, 399, 0, 0},
                     '{0, 0, 0, 0}, '{617, 615, 437, 635}};
  int ty0 [4][4] = '{'{81, 204, 0, 0}, '{81, 205, 0, 0},
                     '{0, 0, 0, 0}, '{18, 124, 239, 344}};
  int ty1 [4][4] = '{'{186, 372, 0, 0}, '{186, 461, 0, 0},
                     '{0, 0, 0, 0}, '{97, 227, 302, 463}};

  int checks = 0;
  int errors = 0;
  int px, py, pvx, pvy, fid, fs_cnt;
  int base [4];
  logic [31:0] cur_mode;
  logic prev_vs;
  logic exp_valid, exp_fs;
  int exp_id, exp_addr;
  logic [23:0] exp_bg;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h x=%0d y=%0d fid=%0d",
               tag, got, exp, pvx, pvy, fid);
    end
  endtask

  function automatic int ov(input int m, input int s, input int len,
                            input int y);
    int hi;
    if (tid[m][s] == 0 || y < ty0[m][s] || y >= ty1[m][s]) return 0;
    hi = (len < tx1[m][s]) ? len : tx1[m][s];
    return (hi > tx0[m][s]) ? hi - tx0[m][s] : 0;
  endfunction

  task automatic spot();
    if (fid == 1 && pvx == 63 && pvy == 81) begin
      chk("a_logo_id", 32'(sprite_id), 1);
      chk("a_logo_first", 32'(rom_addr), 0);
    end
    if (fid == 1 && pvx == 558 && pvy == 81)
      chk("a_logo_eol", 32'(rom_addr), 495);
    if (fid == 1 && pvx == 63 && pvy == 82)
      chk("a_logo_row2", 32'(rom_addr), 496);
    if (fid == 1 && pvx == 558 && pvy == 185)
      chk("a_logo_last", 32'(rom_addr), 52079);
    if ((fid == 1 || fid == 2) && pvx == 228 && pvy == 204) begin
      chk("start_id", 32'(sprite_id), 2);
      chk("start_first", 32'(rom_addr), 0);
    end
    if (fid == 1 && pvx == 0 && pvy == 0)
      chk("a_origin_id", 32'(sprite_id), 0);
    if ((fid == 2 || fid == 3 || fid == 8) && pvx == 63 && pvy == 81)
      chk("logo_restart", 32'(rom_addr), 0);
    if (fid == 3 && pvx == 230 && pvy == 205) begin
      chk("player_id", 32'(sprite_id), 3);
      chk("player_first", 32'(rom_addr), 0);
    end
    if (fid == 4 && pvx == 4 && pvy == 344) begin
      chk("dice_id", 32'(sprite_id), 7);
      chk("dice_first", 32'(rom_addr), 0);
    end
    if (fid == 4 && pvx == 634 && pvy == 344)
      chk("dice_eol", 32'(rom_addr), 630);
    if (fid == 4 && pvx == 4 && pvy == 345)
      chk("dice_row2", 32'(rom_addr), 631);
    if (fid == 5 && pvx == 0 && pvy == 0)
      chk("bg_mode2", 32'(bg_bgr), 32'h946d29);
    if (fid == 6 && pvx == 0 && pvy == 0)
      chk("bg_mode9", 32'(bg_bgr), 32'h150088);
  endtask

  task automatic model(input logic b, input logic v);
    int m;
    exp_fs  = prev_vs && !v;
    prev_vs = v;
    exp_valid = 1'b0;
    exp_id    = 0;
    exp_addr  = 0;
    pvx = -1;
    pvy = -1;
    m = (cur_mode < 32'd4) ? int'(cur_mode) : -1;
    if (!v) begin
      px = 0;
      py = 0;
      for (int s = 0; s < 4; s++) base[s] = 0;
      cur_mode = mode_in;
    end else if (b) begin
      exp_valid = 1'b1;
      pvx = px;
      pvy = py;
      if (m >= 0) begin
        for (int s = 3; s >= 0; s--) begin
          if (tid[m][s] != 0 && px >= tx0[m][s] && px < tx1[m][s]
              && py >= ty0[m][s] && py < ty1[m][s]) begin
            exp_id   = tid[m][s];
            exp_addr = base[s] + px - tx0[m][s];
          end
        end
      end
      px++;
    end else if (px != 0) begin
      if (m >= 0)
        for (int s = 0; s < 4; s++) base[s] += ov(m, s, px, py);
      px = 0;
      py++;
    end
    exp_bg = (cur_mode == 32'd2) ? 24'h946d29 : 24'h150088;
  endtask

  task automatic drive(input logic b, input logic v);
    @(negedge clk);
    chk("pix_valid", 32'(pix_valid), 32'(exp_valid));
    chk("sprite_id", 32'(sprite_id), exp_id);
    chk("rom_addr", 32'(rom_addr), exp_addr);
    chk("bg_bgr", 32'(bg_bgr), 32'(exp_bg));
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
    spot();
    if (frame_start) fs_cnt++;
    blank_n = b;
    vs = v;
    model(b, v);
  endtask

  task automatic line(input int len);
    for (int i = 0; i < len; i++) drive(1'b1, 1'b1);
    for (int i = 0; i < int'($urandom_range(1, 2)); i++)
      drive(1'b0, 1'b1);
  endtask

  task automatic short_rows(input int from, input int to);
    for (int y = from; y <= to; y++) line($urandom_range(1, 8));
  endtask

  task automatic vsync(input logic [31:0] m, input int next_fid);
    mode_in = m;
    fs_cnt = 0;
    drive(1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      drive((i == 1) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    chk("fs_pulses", fs_cnt, 1);
    fid = next_fid;
  endtask

  task automatic do_reset();
    blank_n = 1'b0;
    vs = 1'b1;
    #2 reset = 1'b1;
    @(negedge clk);
    pvx = -1;
    pvy = -1;
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_id", 32'(sprite_id), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_bg", 32'(bg_bgr), 32'h150088);
    chk("rst_fs", 32'(frame_start), 0);
    mode_in = '0;
    @(negedge clk);
    reset = 1'b0;
    px = 0;
    py = 0;
    for (int s = 0; s < 4; s++) base[s] = 0;
    prev_vs = 1'b1;
    cur_mode = '0;
    exp_valid = 1'b0;
    exp_id = 0;
    exp_addr = 0;
    exp_fs = 1'b0;
    exp_bg = 24'h150088;
  endtask

  initial begin
    fid = 0;
    do_reset();

    vsync(32'd0, 1);
    mode_in = $urandom();
    short_rows(0, 80);
    for (int y = 81; y <= 185; y++) line(559);
    short_rows(186, 203);
    line(240);

    vsync(32'd0, 2);
    short_rows(0, 80);
    line(100);
    line(70);
    short_rows(83, 99);
    mode_in = 32'd1;
    short_rows(100, 119);
    line(300);
    short_rows(121, 203);
    line(240);
    line(240);

    vsync(32'd1, 3);
    mode_in = $urandom();
    short_rows(0, 80);
    line(100);
    short_rows(82, 204);
    line(300);
    line(300);

    vsync(32'd3, 4);
    mode_in = $urandom();
    short_rows(0, 17);
    line(640);
    short_rows(19, 123);
    line(640);
    short_rows(125, 238);
    line(640);
    short_rows(240, 343);
    line(640);
    line(640);

    vsync(32'd2, 5);
    for (int i = 0; i < 5; i++) line($urandom_range(1, 640));
    vsync(32'd9, 6);
    for (int i = 0; i < 5; i++) line($urandom_range(1, 640));

    vsync(32'd2, 7);
    line(300);
    for (int i = 0; i < 50; i++) drive(1'b1, 1'b1);
    do_reset();

    vsync(32'd0, 8);
    short_rows(0, 80);
    line(100);
    line(100);
    vsync(32'd0, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Per-pixel sprite scheduler for the VGA display path. Sits between the sync generator and the per-sprite image ROMs. It tracks the active pixel position, latches the screen mode once per frame, and decides which sprite window (if any) owns each pixel. For the winning sprite it issues one ROM address and a sprite ID; when no sprite owns the pixel it issues the mode's background colour. This replaces ad-hoc per-sprite counters with one sequenced, frame-coherent address source.

## Interface
- `BG_DEFAULT`, 24'h150088: background BGR for modes without a dedicated colour.
- `BG_MODE2`, 24'h946d29: background BGR for mode 2.
- `iVGA_CLK` in 1: pixel clock. The only clock.
- `reset` in 1: asynchronous, active-high reset.
- `blank_n` in 1: active-video qualifier from the sync generator.
- `vs` in 1: vertical sync, active low.
- `mode_in` in 32: requested screen mode (processor $30).
- `pix_valid` out 1: the other outputs describe an active pixel.
- `sprite_id` out 3: winning sprite. 0 = none, 1 = logo, 2 = start, 3 = player, 4 = row1, 5 = row2, 6 = row3, 7 = dice.
- `rom_addr` out 19: pixel offset within the winning sprite's ROM.
- `bg_bgr` out 24: background colour for the current frame.
- `frame_start` out 1: one-cycle pulse on the first `vs`-low cycle of a frame.

## Operation
- Position counters: `x` is 10 bits and `y` is 10 bits.
  - On a cycle with `blank_n`=1, the pixel (x,y) is evaluated and `x` increments.
  - On a cycle with `blank_n`=0 and `x`≠0, `x` clears and `y` increments.
  - On a cycle with `vs`=0, `x` and `y` clear and all slot counters clear. `vs` takes priority over the blanking rules.
- Mode latch: `active_mode` loads `mode_in` only while `vs`=0.
  - A mid-frame change of `mode_in` takes effect at the next vertical sync.
  - `bg_bgr` = `BG_MODE2` when `active_mode`==2, otherwise `BG_DEFAULT`.
- Sprite table: each mode has up to 4 slots. Each slot holds an ID and a half-open rectangle [x0,x1)×[y0,y1).
  - Mode 0: logo [63,559)×[81,186); start [228,400)×[204,372).
  - Mode 1: logo as mode 0; player [230,399)×[205,461).
  - Mode 2: no slots.
  - Mode 3: row1 [18,617)×[18,97); row2 [31,615)×[124,227); row3 [195,437)×[239,302); dice [4,635)×[344,463).
  - Modes ≥4: no slots.
- Slot counters: 4 counters, 19 bits each.
  - A slot's counter increments on every evaluated pixel inside that slot's rectangle, whether or not the slot wins. This keeps partially covered sprites unsheared.
  - The counter cannot wrap within a frame, because the maximum area (640×480) is less than 2^19.
- Priority: the lowest-numbered hitting slot wins.
  - `rom_addr` = the winner's counter value before its increment.
  - No hit gives `sprite_id`=0 and `rom_addr`=0.

## Timing
- Output latency is 1 cycle. Outputs are registered at the edge that samples `blank_n`=1 for pixel (x,y) and describe that pixel.
- When the sampled `blank_n`=0, outputs are `pix_valid`=0, `sprite_id`=0 and `rom_addr`=0.
- `frame_start` is registered and asserts on the edge after `vs` is first sampled low (falling edge of `vs`).
- A sprite's first pixel always reads `rom_addr`=0. Row-major continuity requires the address at (x0, y+1) to equal the address at (x1−1, y) plus 1.
- Reset state:
  - x=0, y=0, all slot counters 0, `active_mode`=0.
  - `pix_valid`=0, `sprite_id`=0, `rom_addr`=0, `bg_bgr`=`BG_DEFAULT`, `frame_start`=0.
  - Reset asserted mid-frame discards the frame. After release, the block produces correct addresses only from the next `vs` onward. Position is nonetheless tracked from the release point.
- Simultaneous `vs`=0 and `blank_n`=1 (malformed timing): clearing wins and no pixel is evaluated.

## Structure
- The `sprite_pkg` package holds:
  - Sprite ID constants.
  - The per-mode slot table: `x0`, `x1`, `y0`, `y1`, `id`, and a valid bit.
  - The BGR constants.
  - The `MAX_SLOTS`=4 constant.
- One sub-module, `sprite_slot`: a rectangle hit test plus its 19-bit counter, instantiated 4×. The slot's rectangle is selected by `active_mode` from the package table.
- The top level contains the position counters, the mode latch, the priority encoder and the output registers.

## Test plan
- Reset asserted mid-line, then released with `mode_in`=0 → all outputs at their reset values, including `bg_bgr`=24'h150088.
- Mode 0, full 640×480 frame:
  - (63,81) → `sprite_id`=1, `rom_addr`=0.
  - (558,81) → `rom_addr`=495.
  - (63,82) → `rom_addr`=496.
  - (558,185) → `rom_addr`=52079.
  - (228,204) → `sprite_id`=2, `rom_addr`=0.
  - (0,0) → `sprite_id`=0.
- Mode 3 → (4,344) gives `sprite_id`=7, `rom_addr`=0; (634,462) gives `rom_addr`=75088.
- `mode_in` switched 0→1 at y=100 → logo and start addresses continue for the rest of the frame. The next frame shows player at (230,205) with `rom_addr`=0, `frame_start` pulsing once.
- `mode_in`=2, then `mode_in`=9 → `bg_bgr`=24'h946d29, then 24'h150088; `sprite_id`=0 for every pixel.
- Second consecutive mode 0 frame → logo `rom_addr` restarts at 0, confirming the counters clear on `vs`.
